// File: rtl/present_pkg.sv
// present_pkg: shared definitions for the PRESENT-80 cipher blocks.
//   - block/key widths and round count
//   - the 4-bit PRESENT S-box table and a lookup helper
//   - controller FSM state encoding
package present_pkg;

  localparam int PRESENT_BLOCK_W = 64;
  localparam int PRESENT_KEY_W   = 80;
  localparam int PRESENT_ROUNDS  = 31;

  // S(x) lives in nibble x (S(0)=C in bits [3:0], S(15)=2 in bits [63:60]).
  localparam logic [63:0] PRESENT_SBOX = 64'h2174_8FE3_DA09_B65C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } present_fsm_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return PRESENT_SBOX[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/present_enc_ctrl_if.sv
// present_enc_ctrl_if: request/response handshake bundle of the PRESENT
// encryption controller.
//   in_valid/in_ready       : request handshake (plaintext + key)
//   in_plaintext, in_key    : 64-bit block and 80-bit cipher key
//   out_valid/out_ready     : response handshake
//   out_ciphertext          : 64-bit result
// modport master: host side; modport slave: engine side.
interface present_enc_ctrl_if;
  import present_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [PRESENT_BLOCK_W-1:0] in_plaintext;
  logic [PRESENT_KEY_W-1:0]   in_key;
  logic                       out_valid;
  logic                       out_ready;
  logic [PRESENT_BLOCK_W-1:0] out_ciphertext;

  modport master (
    output in_valid, in_plaintext, in_key, out_ready,
    input  in_ready, out_valid, out_ciphertext
  );

  modport slave (
    input  in_valid, in_plaintext, in_key, out_ready,
    output in_ready, out_valid, out_ciphertext
  );

endinterface

// File: rtl/present_enc_ctrl_key_update.sv
// present_key_update: one combinational step of the PRESENT-80 key schedule.
//   key      : current 80-bit key register
//   rc       : round counter of the round being applied
//   key_next : key register for the following round
// Step order: rotate left by 61, S-box on the top nibble, XOR the 5-bit
// round counter into bits [19:15].
module present_key_update
  import present_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic [PRESENT_KEY_W-1:0] key,
  input  logic [CNT_W-1:0]         rc,
  output logic [PRESENT_KEY_W-1:0] key_next
);

  logic [PRESENT_KEY_W-1:0] rot;
  logic [4:0]               rc5;

  // Rotating left by 61 equals rotating right by 19.
  assign rot = {key[18:0], key[79:19]};
  assign rc5 = 5'(rc);

  assign key_next = {sbox4(rot[79:76]), rot[75:20], rot[19:15] ^ rc5, rot[14:0]};

endmodule

// File: rtl/present_enc_ctrl.sv
// present_enc_ctrl: iterative PRESENT-80 encryption controller.
// One round (addRoundKey, S-box layer, P-layer) per clock over NUM_ROUNDS
// rounds with an on-the-fly key schedule, then a final key addition that is
// registered into out_ciphertext.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   bus       : request/response handshakes (slave side)
//   busy      : high while running or holding a result
//   round_cnt : current round index (1..NUM_ROUNDS while running, 0 idle)
// CNT_W must satisfy 2**CNT_W > NUM_ROUNDS.
module present_enc_ctrl
  import present_pkg::*;
#(
  parameter int NUM_ROUNDS = PRESENT_ROUNDS,
  parameter int CNT_W      = 5
) (
  input  logic               clk,
  input  logic               rst,
  present_enc_ctrl_if.slave  bus,
  output logic               busy,
  output logic [CNT_W-1:0]   round_cnt
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] OUT  = ST_OUT;
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);

  logic [1:0]                 fsm_reg;
  logic [PRESENT_BLOCK_W-1:0] state_reg;
  logic [PRESENT_KEY_W-1:0]   key_reg;
  logic [CNT_W-1:0]           round_cnt_reg;
  logic [PRESENT_BLOCK_W-1:0] ct_reg;
  logic                       out_valid_reg;

  logic [PRESENT_BLOCK_W-1:0] ark;
  logic [PRESENT_BLOCK_W-1:0] sbox_out;
  logic [PRESENT_BLOCK_W-1:0] perm_out;
  logic [PRESENT_KEY_W-1:0]   key_next;
  logic                       in_ready_int;

  // Round datapath. The same XOR also forms the final whitening in OUT.
  assign ark = state_reg ^ key_reg[79:16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sbox
      assign sbox_out[gi*4 +: 4] = sbox4(ark[gi*4 +: 4]);
    end
    // Bit i moves to 16*i mod 63; bit 63 stays in place.
    for (gi = 0; gi < 63; gi++) begin : g_perm
      assign perm_out[(16*gi) % 63] = sbox_out[gi];
    end
  endgenerate
  assign perm_out[63] = sbox_out[63];

  present_key_update #(
    .CNT_W (CNT_W)
  ) u_key_update (
    .key      (key_reg),
    .rc       (round_cnt_reg),
    .key_next (key_next)
  );

  // in_ready stays low while reset is held.
  assign in_ready_int = (fsm_reg == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      key_reg       <= '0;
      round_cnt_reg <= '0;
      ct_reg        <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_int) begin
            state_reg     <= bus.in_plaintext;
            key_reg       <= bus.in_key;
            round_cnt_reg <= CNT_W'(1);
            fsm_reg       <= RUN;
          end
        end
        RUN: begin
          state_reg <= perm_out;
          key_reg   <= key_next;
          // Counter parks on the last round so it never exceeds NUM_ROUNDS.
          if (round_cnt_reg == LAST_ROUND) begin
            fsm_reg <= OUT;
          end else begin
            round_cnt_reg <= round_cnt_reg + CNT_W'(1);
          end
        end
        OUT: begin
          // First OUT cycle registers the whitened result; out_valid then
          // holds with stable data until the consumer takes it.
          if (!out_valid_reg) begin
            ct_reg        <= ark;
            out_valid_reg <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            round_cnt_reg <= '0;
            fsm_reg       <= IDLE;
          end
        end
        default: begin
          fsm_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready       = in_ready_int;
  assign bus.out_valid      = out_valid_reg;
  assign bus.out_ciphertext = ct_reg;
  assign busy               = (fsm_reg != IDLE);
  assign round_cnt          = round_cnt_reg;

endmodule

// File: tb/tb_present_enc_ctrl.sv
// tb_present_enc_ctrl: directed testbench for present_enc_ctrl using the
// published PRESENT-80 test vectors.
module tb_present_enc_ctrl;
  import present_pkg::*;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] round_cnt;

  int checks = 0;
  int passes = 0;

  logic [CNT_W-1:0] rc_hist [128];

  present_enc_ctrl_if bus_if ();

  present_enc_ctrl #(
    .NUM_ROUNDS (31),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .busy      (busy),
    .round_cnt (round_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and waits for out_valid (bounded). lat is the number
  // of edges after the accept edge at which out_valid was first seen.
  task automatic run_block(input logic [63:0] pt, input logic [79:0] key,
                           input bit scramble, output logic [63:0] ct,
                           output int lat, output int accepts);
    bus_if.in_plaintext = pt;
    bus_if.in_key       = key;
    bus_if.in_valid     = 1'b1;
    bus_if.out_ready    = 1'b0;
    accepts = 0;
    lat     = -1;
    ct      = '0;
    for (int n = 0; n < 100; n++) begin
      if (bus_if.in_valid && bus_if.in_ready) accepts++;
      step();
      rc_hist[n] = round_cnt;
      if (bus_if.out_valid) begin
        lat = n;
        ct  = bus_if.out_ciphertext;
        bus_if.in_valid = 1'b0;
        break;
      end
      if (scramble) begin
        bus_if.in_plaintext = {$urandom(), $urandom()};
        bus_if.in_key       = {16'($urandom()), $urandom(), $urandom()};
      end else begin
        bus_if.in_valid = 1'b0;
      end
    end
  endtask

  task automatic handshake();
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.in_valid     = 1'b0;
    bus_if.out_ready    = 1'b0;
    bus_if.in_plaintext = '0;
    bus_if.in_key       = '0;
    repeat (3) step();
    checks++; if (bus_if.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    checks++; if (round_cnt !== 5'd0) $display("FAIL reset_round_cnt got=%0d exp=0", round_cnt); else passes++;
    checks++; if (bus_if.out_ciphertext !== 64'h0) $display("FAIL reset_ct got=%h exp=0", bus_if.out_ciphertext); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (bus_if.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus_if.in_ready); else passes++;
    $display("reset: done");
  endtask

  task automatic test_zero_vector();
    logic [63:0] ct;
    int lat, acc, bad;
    run_block(64'h0, 80'h0, 1'b0, ct, lat, acc);
    $display("txn pt=0 key=0 ct=%h lat=%0d", ct, lat);
    checks++; if (ct !== 64'h5579C1387B228445) $display("FAIL zero_ct got=%h exp=5579c1387b228445", ct); else passes++;
    checks++; if (lat !== 32) $display("FAIL zero_latency got=%0d exp=32", lat); else passes++;
    checks++; if (acc !== 1) $display("FAIL zero_accepts got=%0d exp=1", acc); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL zero_busy_out got=%b exp=1", busy); else passes++;
    bad = -1;
    for (int k = 0; k < 31; k++) if (bad < 0 && rc_hist[k] !== 5'(k + 1)) bad = k;
    checks++; if (bad >= 0) $display("FAIL zero_round_trace at=%0d got=%0d exp=%0d", bad, rc_hist[bad], bad + 1); else passes++;
    checks++; if (rc_hist[31] !== 5'd31) $display("FAIL zero_round_hold got=%0d exp=31", rc_hist[31]); else passes++;
    handshake();
    checks++; if (bus_if.out_valid !== 1'b0) $display("FAIL zero_hs_out_valid got=%b exp=0", bus_if.out_valid); else passes++;
    checks++; if (round_cnt !== 5'd0) $display("FAIL zero_hs_round_cnt got=%0d exp=0", round_cnt); else passes++;
    checks++; if (bus_if.in_ready !== 1'b1) $display("FAIL zero_hs_in_ready got=%b exp=1", bus_if.in_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL zero_hs_busy got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_key_ones();
    logic [63:0] ct;
    int lat, acc;
    run_block(64'h0, {80{1'b1}}, 1'b0, ct, lat, acc);
    $display("txn pt=0 key=f..f ct=%h lat=%0d", ct, lat);
    checks++; if (ct !== 64'hE72C46C0F5945049) $display("FAIL keyones_ct got=%h exp=e72c46c0f5945049", ct); else passes++;
    checks++; if (lat !== 32) $display("FAIL keyones_latency got=%0d exp=32", lat); else passes++;
    handshake();
    checks++; if (bus_if.out_valid !== 1'b0) $display("FAIL keyones_hs got=%b exp=0", bus_if.out_valid); else passes++;
  endtask

  task automatic test_backpressure();
    logic [63:0] ct;
    int lat, acc;
    run_block({64{1'b1}}, 80'h0, 1'b0, ct, lat, acc);
    $display("txn pt=f..f key=0 ct=%h lat=%0d", ct, lat);
    checks++; if (ct !== 64'hA112FFC72F68417B) $display("FAIL bp_ct got=%h exp=a112ffc72f68417b", ct); else passes++;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus_if.out_valid !== 1'b1) $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, bus_if.out_valid); else passes++;
      checks++; if (bus_if.out_ciphertext !== 64'hA112FFC72F68417B) $display("FAIL bp_hold_ct cyc=%0d got=%h exp=a112ffc72f68417b", i, bus_if.out_ciphertext); else passes++;
      checks++; if (bus_if.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus_if.in_ready); else passes++;
    end
    handshake();
    checks++; if (bus_if.out_valid !== 1'b0) $display("FAIL bp_hs got=%b exp=0", bus_if.out_valid); else passes++;
  endtask

  task automatic test_input_scramble();
    logic [63:0] ct;
    int lat, acc;
    run_block({64{1'b1}}, {80{1'b1}}, 1'b1, ct, lat, acc);
    $display("txn pt=f..f key=f..f scrambled ct=%h lat=%0d accepts=%0d", ct, lat, acc);
    checks++; if (ct !== 64'h3333DCD3213210D2) $display("FAIL scramble_ct got=%h exp=3333dcd3213210d2", ct); else passes++;
    checks++; if (acc !== 1) $display("FAIL scramble_accepts got=%0d exp=1", acc); else passes++;
    checks++; if (lat !== 32) $display("FAIL scramble_latency got=%0d exp=32", lat); else passes++;
    handshake();
  endtask

  task automatic test_reset_mid();
    logic [63:0] ct;
    int lat, acc;
    bit found;
    bus_if.in_plaintext = 64'h0123456789ABCDEF;
    bus_if.in_key       = 80'h13579BDF02468ACE1234;
    bus_if.in_valid     = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (round_cnt == 5'd15) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++; if (!found) $display("FAIL midrst_reach_round15 got=%0d exp=15", round_cnt); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_if.out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", bus_if.out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passes++;
    checks++; if (round_cnt !== 5'd0) $display("FAIL midrst_round_cnt got=%0d exp=0", round_cnt); else passes++;
    step();
    rst = 1'b0;
    #1;
    run_block(64'h0, 80'h0, 1'b0, ct, lat, acc);
    $display("txn after reset pt=0 key=0 ct=%h lat=%0d", ct, lat);
    checks++; if (ct !== 64'h5579C1387B228445) $display("FAIL midrst_ct got=%h exp=5579c1387b228445", ct); else passes++;
    checks++; if (lat !== 32) $display("FAIL midrst_latency got=%0d exp=32", lat); else passes++;
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [63:0]      cts [2];
    int               acc_at [2];
    int               hs_at [2];
    logic [CNT_W-1:0] hist [128];
    int n_acc, n_out, bad;
    bit acc_now, hs_now;
    n_acc = 0;
    n_out = 0;
    cts[0] = '0; cts[1] = '0;
    acc_at[0] = -100; acc_at[1] = -100;
    hs_at[0] = -100; hs_at[1] = -100;
    bus_if.out_ready    = 1'b1;
    bus_if.in_valid     = 1'b1;
    bus_if.in_plaintext = 64'h0;
    bus_if.in_key       = 80'h0;
    for (int n = 0; n < 120 && n_out < 2; n++) begin
      acc_now = bus_if.in_valid && bus_if.in_ready;
      hs_now  = bus_if.out_valid && bus_if.out_ready;
      if (hs_now && n_out < 2) begin
        cts[n_out]   = bus_if.out_ciphertext;
        hs_at[n_out] = n;
        n_out++;
      end
      if (acc_now && n_acc < 2) begin
        acc_at[n_acc] = n;
        n_acc++;
      end
      hist[n] = round_cnt;
      if (n_out < 2) begin
        step();
        if (acc_now) begin
          if (n_acc == 1) begin
            bus_if.in_plaintext = {64{1'b1}};
            bus_if.in_key       = {80{1'b1}};
          end else begin
            bus_if.in_valid = 1'b0;
          end
        end
      end
    end
    step();
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b0;
    $display("txn b2b acc=%0d,%0d hs=%0d,%0d ct0=%h ct1=%h", acc_at[0], acc_at[1], hs_at[0], hs_at[1], cts[0], cts[1]);
    checks++; if (n_out !== 2) $display("FAIL b2b_outputs got=%0d exp=2", n_out); else passes++;
    checks++; if (cts[0] !== 64'h5579C1387B228445) $display("FAIL b2b_ct0 got=%h exp=5579c1387b228445", cts[0]); else passes++;
    checks++; if (cts[1] !== 64'h3333DCD3213210D2) $display("FAIL b2b_ct1 got=%h exp=3333dcd3213210d2", cts[1]); else passes++;
    checks++; if (hs_at[0] !== 33) $display("FAIL b2b_hs0_cycle got=%0d exp=33", hs_at[0]); else passes++;
    checks++; if (acc_at[1] !== 34) $display("FAIL b2b_acc1_cycle got=%0d exp=34", acc_at[1]); else passes++;
    for (int b = 0; b < 2; b++) begin
      bad = -1;
      if (acc_at[b] >= 0) begin
        for (int k = 0; k < 31; k++)
          if (bad < 0 && hist[acc_at[b] + 1 + k] !== 5'(k + 1)) bad = k;
      end else begin
        bad = 0;
      end
      checks++; if (bad >= 0) $display("FAIL b2b_round_trace blk=%0d at=%0d exp=%0d", b, bad, bad + 1); else passes++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL b2b_final_busy got=%b exp=0", busy); else passes++;
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_key_ones();
    test_backpressure();
    test_input_scramble();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
